// File: rtl/seq_det_param_if.sv
//==============================================================================
// Module      : seq_det_param_if
// Description : Serial-bit bus between a bit source (master) and the
//               sequence detector (slave). Carries the data bit, the
//               qualifier, the synchronous clear, and the detector's match
//               outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface seq_det_param_if #(
   parameter int CNT_W = 8
);
   logic             d_in;
   logic             d_valid;
   logic             clr;
   logic             d_out;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   // The bit source drives the stream and observes the detector results.
   modport master (
      output d_in,
      output d_valid,
      output clr,
      input  d_out,
      input  match_cnt,
      input  cnt_sat
   );

   // The detector consumes the stream and reports matches.
   modport slave (
      input  d_in,
      input  d_valid,
      input  clr,
      output d_out,
      output match_cnt,
      output cnt_sat
   );
endinterface

`default_nettype wire

// File: rtl/seq_det_param.sv
//==============================================================================
// Module      : seq_det_param
// Description : Parameterised serial pattern detector. It keeps a LEN-1 bit
//               history and a fill count, and makes a Mealy decision on each
//               consumed bit. The match pulse is registered, so it appears
//               one cycle after the completing bit. Overlapping or
//               non-overlapping detection is selectable. When the macro
//               SEQ_DET_MATCH_CNT_EN is defined, an optional saturating
//               match counter is included.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_det_param #(
   parameter int             LEN     = 3,
   parameter logic [LEN-1:0] PATTERN = 3'b111,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   seq_det_param_if.slave     bus
);

   // The fill count only needs to reach LEN-1.
   localparam int             c_FW       = (LEN > 2) ? $clog2(LEN) : 1;
   localparam logic [c_FW-1:0] c_FILL_MAX = c_FW'(LEN - 1);

   logic [LEN-2:0]  r_hist;
   logic [c_FW-1:0] r_fill;
   logic            r_dout;

   logic [LEN-1:0]  w_cand;
   logic            w_match;

   // Candidate window: the stored history followed by the incoming bit as the newest bit.
   assign w_cand  = {r_hist, bus.d_in};
   assign w_match = bus.d_valid && (r_fill == c_FILL_MAX) && (w_cand == PATTERN);

   // History, fill and registered match pulse; reset beats clr, and clr beats d_valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hist <= '0;
         r_fill <= '0;
         r_dout <= 1'b0;
      end else if (bus.clr) begin
         r_hist <= '0;
         r_fill <= '0;
         r_dout <= 1'b0;
      end else begin
         r_dout <= w_match;
         if (bus.d_valid) begin
            r_hist <= w_cand[LEN-2:0];
            if (w_match && !OVERLAP) begin
               // A non-overlapping match needs LEN fresh bits before the next one.
               r_fill <= '0;
            end else if (r_fill != c_FILL_MAX) begin
               r_fill <= r_fill + c_FW'(1);
            end
         end
      end
   end

   assign bus.d_out = r_dout;

`ifdef SEQ_DET_MATCH_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Saturating match counter; it holds at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (bus.clr) begin
         r_cnt <= '0;
      end else if (w_match && !(&r_cnt)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.match_cnt = r_cnt;
   assign bus.cnt_sat   = &r_cnt;
`else
   assign bus.match_cnt = '0;
   assign bus.cnt_sat   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_det_param.sv
//==============================================================================
// Module      : tb_seq_det_param
// Description : Directed self-checking bench for seq_det_param. Four
//               configurations share one stimulus stream: defaults,
//               non-overlapping, LEN=4/1011, and CNT_W=2.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_det_param;

`ifdef SEQ_DET_MATCH_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic clk;
   logic r_rst;
   logic r_d_in;
   logic r_d_valid;
   logic r_clr;

   int n_checks;
   int n_errors;

   seq_det_param_if #(.CNT_W(8)) if0 ();
   seq_det_param_if #(.CNT_W(8)) if1 ();
   seq_det_param_if #(.CNT_W(8)) if2 ();
   seq_det_param_if #(.CNT_W(2)) if3 ();

   assign if0.d_in = r_d_in;  assign if0.d_valid = r_d_valid;  assign if0.clr = r_clr;
   assign if1.d_in = r_d_in;  assign if1.d_valid = r_d_valid;  assign if1.clr = r_clr;
   assign if2.d_in = r_d_in;  assign if2.d_valid = r_d_valid;  assign if2.clr = r_clr;
   assign if3.d_in = r_d_in;  assign if3.d_valid = r_d_valid;  assign if3.clr = r_clr;

   seq_det_param u0 (.clk(clk), .rst(r_rst), .bus(if0.slave));

   seq_det_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(r_rst), .bus(if1.slave));

   seq_det_param #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1))
      u2 (.clk(clk), .rst(r_rst), .bus(if2.slave));

   seq_det_param #(.CNT_W(2)) u3 (.clk(clk), .rst(r_rst), .bus(if3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs, then sample 1 ns after the rising edge.
   task automatic step(input logic din, input logic vld, input logic cl);
      r_d_in    = din;
      r_d_valid = vld;
      r_clr     = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      r_rst = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      r_rst = 1'b1;
   endtask

   task automatic test_reset();
      r_rst = 1'b0;
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({if0.d_out, if1.d_out, if2.d_out, if3.d_out} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_dout: got %b expected 0000",
                  {if0.d_out, if1.d_out, if2.d_out, if3.d_out});
      end
      n_checks++;
      if (if0.match_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL reset_cnt: got %0d expected 0", if0.match_cnt);
      end
      n_checks++;
      if ({if3.match_cnt, if3.cnt_sat} !== 3'b000) begin
         n_errors++;
         $display("FAIL reset_cnt_sat: got cnt=%0d sat=%b expected 0/0", if3.match_cnt, if3.cnt_sat);
      end
      r_rst = 1'b1;
   endtask

   // Overlapping 111 on five ones: pulses after bits 3, 4 and 5.
   task automatic test_overlap();
      logic [4:0] exp_v;
      exp_v = 5'b11100;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b0);
         n_checks++;
         if (if0.d_out !== exp_v[i]) begin
            n_errors++;
            $display("FAIL overlap_bit%0d: got %b expected %b", i + 1, if0.d_out, exp_v[i]);
         end
      end
      n_checks++;
      if (if0.match_cnt !== 8'(3 * CNT_ON)) begin
         n_errors++;
         $display("FAIL overlap_cnt: got %0d expected %0d", if0.match_cnt, 3 * CNT_ON);
      end
   endtask

   // Non-overlapping 111 on six ones: pulses after bits 3 and 6 only.
   task automatic test_non_overlap();
      logic [5:0] exp_v;
      exp_v = 6'b100100;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 1'b0);
         n_checks++;
         if (if1.d_out !== exp_v[i]) begin
            n_errors++;
            $display("FAIL nonoverlap_bit%0d: got %b expected %b", i + 1, if1.d_out, exp_v[i]);
         end
      end
      n_checks++;
      if (if1.match_cnt !== 8'(2 * CNT_ON)) begin
         n_errors++;
         $display("FAIL nonoverlap_cnt: got %0d expected %0d", if1.match_cnt, 2 * CNT_ON);
      end
   endtask

   // LEN=4 pattern 1011 on the stream 1,0,1,1,0,1,1: pulses after bits 4 and 7.
   task automatic test_len4();
      logic [6:0] stim;
      logic [6:0] exp_v;
      stim  = 7'b1101101;   // bit i is stream position i+1
      exp_v = 7'b1001000;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(stim[i], 1'b1, 1'b0);
         n_checks++;
         if (if2.d_out !== exp_v[i]) begin
            n_errors++;
            $display("FAIL len4_bit%0d: got %b expected %b", i + 1, if2.d_out, exp_v[i]);
         end
      end
      n_checks++;
      if (if2.match_cnt !== 8'(2 * CNT_ON)) begin
         n_errors++;
         $display("FAIL len4_cnt: got %0d expected %0d", if2.match_cnt, 2 * CNT_ON);
      end
   endtask

   // A d_valid gap holds progress and produces no pulse.
   task automatic test_gap();
      logic [4:0] vld;
      logic [4:0] exp_v;
      vld   = 5'b01011;
      exp_v = 5'b01000;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, vld[i], 1'b0);
         n_checks++;
         if (if0.d_out !== exp_v[i]) begin
            n_errors++;
            $display("FAIL gap_step%0d: got %b expected %b", i + 1, if0.d_out, exp_v[i]);
         end
      end
      n_checks++;
      if (if0.match_cnt !== 8'(CNT_ON)) begin
         n_errors++;
         $display("FAIL gap_cnt: got %0d expected %0d", if0.match_cnt, CNT_ON);
      end
   endtask

   // A mid-sequence reset drops progress; clr drops its own sample and the counter.
   task automatic test_reset_mid_and_clr();
      logic [2:0] exp_v;
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      r_rst = 1'b0;
      step(1'b1, 1'b1, 1'b0);
      r_rst = 1'b1;
      n_checks++;
      if (if0.d_out !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_dout: got %b expected 0", if0.d_out);
      end
      exp_v = 3'b100;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0);
         n_checks++;
         if (if0.d_out !== exp_v[i]) begin
            n_errors++;
            $display("FAIL midrst_bit%0d: got %b expected %b", i + 1, if0.d_out, exp_v[i]);
         end
      end
      n_checks++;
      if (if0.match_cnt !== 8'(CNT_ON)) begin
         n_errors++;
         $display("FAIL midrst_cnt: got %0d expected %0d", if0.match_cnt, CNT_ON);
      end
      // The history is full of ones, so this bit would match without clr.
      step(1'b1, 1'b1, 1'b1);
      n_checks++;
      if ({if0.d_out, if0.match_cnt} !== 9'd0) begin
         n_errors++;
         $display("FAIL clr_state: got dout=%b cnt=%0d expected 0/0", if0.d_out, if0.match_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0);
         n_checks++;
         if (if0.d_out !== exp_v[i]) begin
            n_errors++;
            $display("FAIL postclr_bit%0d: got %b expected %b", i + 1, if0.d_out, exp_v[i]);
         end
      end
   endtask

   // CNT_W=2: seven ones give five matches; the count saturates at 3.
   task automatic test_saturate();
      int exp_cnt;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b1, 1'b0);
         exp_cnt = (i < 2) ? 0 : ((i - 1 > 3) ? 3 : i - 1);
         exp_cnt = exp_cnt * CNT_ON;
         n_checks++;
         if ({if3.match_cnt, if3.cnt_sat} !== {2'(exp_cnt), (exp_cnt == 3)}) begin
            n_errors++;
            $display("FAIL sat_bit%0d: got cnt=%0d sat=%b expected cnt=%0d sat=%b",
                     i + 1, if3.match_cnt, if3.cnt_sat, exp_cnt, (exp_cnt == 3));
         end
      end
      n_checks++;
      if (if3.d_out !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_dout: got %b expected 1", if3.d_out);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      r_rst     = 1'b0;
      r_d_in    = 1'b0;
      r_d_valid = 1'b0;
      r_clr     = 1'b0;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_len4();
      test_gap();
      test_reset_mid_and_clr();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
